// File: rtl/spi_mem_pkg.sv
// Shared opcodes, widths and FSM state type for the SPI serial-SRAM target.
package spi_mem_pkg;

    localparam int ADDR_W = 16;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_WRSR  = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_RDSR,
        S_WRSR,
        S_IGNORE
    } state_t;

endpackage

// File: rtl/spi_target_sync.sv
// Two-flop synchronizers for the SPI pins plus SCK edge detect.
// sync_valid rises once the CS synchronizer holds a real pin sample,
// so the reset value of the CS flops is never mistaken for a deselect.
module spi_target_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sync_valid
);

    logic [2:0] sck_q,  sck_d;
    logic [1:0] cs_q,   cs_d;
    logic [1:0] mosi_q, mosi_d;
    logic [1:0] fill_q, fill_d;

    // Shift each pin into its synchronizer chain; fill tracks pipeline warm-up after reset
    always_comb begin
        sck_d  = {sck_q[1:0], spi_clk};
        cs_d   = {cs_q[0], spi_cs_n};
        mosi_d = {mosi_q[0], spi_mosi};
        fill_d = {fill_q[0], 1'b1};
    end

    // Synchronizer registers; CS resets to deselected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q  <= 3'b000;
            cs_q   <= 2'b11;
            mosi_q <= 2'b00;
            fill_q <= 2'b00;
        end else begin
            sck_q  <= sck_d;
            cs_q   <= cs_d;
            mosi_q <= mosi_d;
            fill_q <= fill_d;
        end
    end

    assign sck_rise   =  sck_q[1] & ~sck_q[2];
    assign sck_fall   = ~sck_q[1] &  sck_q[2];
    assign cs_n_s     = cs_q[1];
    assign mosi_s     = mosi_q[1];
    assign sync_valid = fill_q[1];

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 responder emulating a 23LC512-style serial SRAM
// (READ/WRITE/RDSR/WRSR, sequential auto-increment) over a DEPTH-byte array.
module spi_sram_target
    import spi_mem_pkg::*;
#(
    parameter int         DEPTH   = 256,
    parameter logic [7:0] SR_INIT = 8'h40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic active,
    output logic cmd_err
);

    localparam int AW = $clog2(DEPTH);

    logic sck_rise, sck_fall, cs_n_s, mosi_s, sync_valid;

    spi_target_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .cs_n_s     (cs_n_s),
        .mosi_s     (mosi_s),
        .sync_valid (sync_valid)
    );

    state_t          state_q,    state_d;
    logic [2:0]      bit_cnt_q,  bit_cnt_d;
    logic [3:0]      addr_cnt_q, addr_cnt_d;
    logic [14:0]     rx_shift_q, rx_shift_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [AW-1:0]   addr_q,     addr_d;
    logic [7:0]      sr_q,       sr_d;
    logic            is_read_q,  is_read_d;
    logic            miso_q,     miso_d;
    logic            cmd_err_q,  cmd_err_d;
    logic            armed_q,    armed_d;

    logic [7:0]      mem [DEPTH];
    logic            mem_we;
    logic [7:0]      rx_byte;
    logic            byte_done;
    logic [AW-1:0]   addr_new;
    logic [AW-1:0]   addr_inc;

    // Next-state, datapath and memory-write decode; deselect overrides everything
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        addr_cnt_d = addr_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        addr_d     = addr_q;
        sr_d       = sr_q;
        is_read_d  = is_read_q;
        miso_d     = miso_q;
        cmd_err_d  = 1'b0;
        mem_we     = 1'b0;
        // Only a deselect observed after reset may arm the next command
        armed_d    = armed_q | (sync_valid & cs_n_s);
        rx_byte    = {rx_shift_q[6:0], mosi_s};
        byte_done  = sck_rise && (bit_cnt_q == 3'd7);
        addr_new   = AW'({rx_shift_q, mosi_s});
        addr_inc   = addr_q + AW'(1);

        if (cs_n_s) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 3'd0;
            addr_cnt_d = 4'd0;
            rx_shift_d = '0;
            tx_shift_d = '0;
            miso_d     = 1'b0;
        end else begin
            if (sck_rise) begin
                rx_shift_d = {rx_shift_q[13:0], mosi_s};
            end
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        state_d = S_CMD;
                    end
                end
                S_CMD: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        case (rx_byte)
                            CMD_READ:  begin state_d = S_ADDR; is_read_d = 1'b1; end
                            CMD_WRITE: begin state_d = S_ADDR; is_read_d = 1'b0; end
                            CMD_RDSR:  begin state_d = S_RDSR; tx_shift_d = sr_q; end
                            CMD_WRSR:  state_d = S_WRSR;
                            default:   begin state_d = S_IGNORE; cmd_err_d = 1'b1; end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        addr_cnt_d = addr_cnt_q + 4'd1;
                        if (addr_cnt_q == 4'd15) begin
                            addr_d = addr_new;
                            if (is_read_q) begin
                                state_d    = S_READ;
                                tx_shift_d = mem[addr_new];
                            end else begin
                                state_d = S_WRITE;
                            end
                        end
                    end
                end
                S_READ, S_RDSR: begin
                    if (sck_fall) begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (byte_done) begin
                            if (state_q == S_READ) begin
                                addr_d     = addr_inc;
                                tx_shift_d = mem[addr_inc];
                            end else begin
                                tx_shift_d = sr_q;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        mem_we = 1'b1;
                        addr_d = addr_inc;
                    end
                end
                S_WRSR: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        sr_d    = {rx_byte[7:6], 6'b0};
                        state_d = S_IGNORE;
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            addr_cnt_q <= 4'd0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            addr_q     <= '0;
            sr_q       <= SR_INIT;
            is_read_q  <= 1'b0;
            miso_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            addr_q     <= addr_d;
            sr_q       <= sr_d;
            is_read_q  <= is_read_d;
            miso_q     <= miso_d;
            cmd_err_q  <= cmd_err_d;
            armed_q    <= armed_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= rx_byte;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ((state_q == S_READ) || (state_q == S_RDSR)) && !cs_n_s;
    assign active      = ~cs_n_s;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Bench for spi_sram_target: mode-0 initiator at SCK = clk/8, byte-array
// reference memory and status-register model, random and directed transactions.
`timescale 1ns/1ps
module tb_spi_sram_target;

    localparam int DEPTH = 256;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic spi_clk  = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, active, cmd_err;

    spi_sram_target #(.DEPTH(DEPTH), .SR_INIT(8'h40)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .active      (active),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_fail     = 0;
    int err_cycles = 0;

    logic [7:0] ref_mem [DEPTH];
    logic [7:0] ref_sr;
    logic [7:0] tx_buf [300];
    logic [7:0] rx_buf [300];
    logic [7:0] oe_buf [300];
    logic [7:0] wdata  [260];

    always @(negedge clk) if (cmd_err === 1'b1) err_cycles++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of tx MSB first; miso and oe are sampled just before each SCK rise
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic [7:0] oe);
        rx = 8'h00;
        oe = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(4);
            rx = {rx[6:0], spi_miso};
            oe = {oe[6:0], spi_miso_oe};
            spi_clk = 1'b1;
            wait_clk(4);
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_end();
        wait_clk(4);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_txn(input int n);
        logic [7:0] r, o;
        cs_begin();
        for (int i = 0; i < n; i++) begin
            spi_bits(tx_buf[i], 8, r, o);
            rx_buf[i] = r;
            oe_buf[i] = o;
        end
        cs_end();
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input int n);
        logic [7:0] oe_any;
        tx_buf[0] = 8'h02;
        tx_buf[1] = addr[15:8];
        tx_buf[2] = addr[7:0];
        for (int i = 0; i < n; i++) begin
            tx_buf[3+i] = wdata[i];
            ref_mem[(int'(addr) + i) % DEPTH] = wdata[i];
        end
        spi_txn(n + 3);
        oe_any = 8'h00;
        for (int i = 0; i < n + 3; i++) oe_any = oe_any | oe_buf[i];
        check_eq({tag, " wr_oe"}, {24'h0, oe_any}, 32'h0);
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input int n);
        logic [7:0] oe_all;
        tx_buf[0] = 8'h03;
        tx_buf[1] = addr[15:8];
        tx_buf[2] = addr[7:0];
        for (int i = 0; i < n; i++) tx_buf[3+i] = 8'($urandom);
        spi_txn(n + 3);
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s rd[%0d]", tag, i), {24'h0, rx_buf[3+i]},
                     {24'h0, ref_mem[(int'(addr) + i) % DEPTH]});
        check_eq({tag, " hdr_oe"}, {8'h0, oe_buf[0], oe_buf[1], oe_buf[2]}, 32'h0);
        oe_all = 8'hFF;
        for (int i = 0; i < n; i++) oe_all = oe_all & oe_buf[3+i];
        check_eq({tag, " data_oe"}, {24'h0, oe_all}, 32'hFF);
    endtask

    task automatic do_rdsr(input string tag, input int n);
        tx_buf[0] = 8'h05;
        for (int i = 0; i < n; i++) tx_buf[1+i] = 8'($urandom);
        spi_txn(n + 1);
        check_eq({tag, " cmd_oe"}, {24'h0, oe_buf[0]}, 32'h0);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s sr[%0d]", tag, i), {24'h0, rx_buf[1+i]}, {24'h0, ref_sr});
            check_eq($sformatf("%s sr_oe[%0d]", tag, i), {24'h0, oe_buf[1+i]}, 32'hFF);
        end
    endtask

    task automatic do_wrsr(input logic [7:0] b);
        tx_buf[0] = 8'h01;
        tx_buf[1] = b;
        spi_txn(2);
        ref_sr = {b[7:6], 6'b0};
    endtask

    initial begin
        logic [7:0]  r, o, r_any, o_any;
        logic [15:0] a;
        int          e0, n;

        wait_clk(3);
        check_eq("rst miso",    {31'h0, spi_miso},    32'h0);
        check_eq("rst miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        check_eq("rst active",  {31'h0, active},      32'h0);
        check_eq("rst cmd_err", {31'h0, cmd_err},     32'h0);
        rst_n = 1'b1;
        wait_clk(4);
        check_eq("idle active", {31'h0, active}, 32'h0);

        ref_sr = 8'h40;
        do_rdsr("rdsr_reset", 1);

        // Fill the whole array so every later read has a known expectation
        for (int i = 0; i < DEPTH; i++) wdata[i] = 8'($urandom);
        do_write("preload", 16'($urandom), DEPTH);

        wdata[0] = 8'hDE; wdata[1] = 8'hAD; wdata[2] = 8'hBE; wdata[3] = 8'hEF;
        do_write("deadbeef", 16'h0010, 4);
        do_read("deadbeef", 16'h0010, 4);
        check_eq("deadbeef last", {24'h0, rx_buf[6]}, 32'hEF);

        wdata[0] = 8'h11; wdata[1] = 8'h22;
        do_write("wrap", 16'h00FF, 2);
        do_read("wrap_ff", 16'h00FF, 2);
        do_read("wrap_00", 16'h0000, 1);
        check_eq("wrap byte0", {24'h0, rx_buf[3]}, 32'h22);

        // Abort a write mid-byte: second byte must be discarded
        cs_begin();
        spi_bits(8'h02, 8, r, o);
        spi_bits(8'h00, 8, r, o);
        spi_bits(8'h20, 8, r, o);
        spi_bits(8'hA5, 8, r, o);
        ref_mem[8'h20] = 8'hA5;
        spi_bits(8'hFF, 4, r, o);
        cs_end();
        do_read("cs_abort", 16'h0020, 2);

        do_wrsr(8'h00);
        do_rdsr("wrsr_00", 2);
        do_wrsr(8'($urandom));
        do_rdsr("wrsr_rand", 2);

        // Unsupported opcode: one cmd_err pulse, line stays quiet
        e0 = err_cycles;
        cs_begin();
        spi_bits(8'h9F, 8, r, o);
        r_any = 8'h00; o_any = 8'h00;
        for (int i = 0; i < 3; i++) begin
            spi_bits(8'($urandom), 8, r, o);
            r_any = r_any | r;
            o_any = o_any | o;
        end
        cs_end();
        check_eq("badop cmd_err", err_cycles - e0, 32'd1);
        check_eq("badop miso", {24'h0, r_any}, 32'h0);
        check_eq("badop oe",   {24'h0, o_any}, 32'h0);

        for (int k = 0; k < 30; k++) begin
            a = 16'($urandom);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
                do_write($sformatf("rnd%0d", k), a, n);
            end else begin
                do_read($sformatf("rnd%0d", k), a, n);
            end
        end

        // Reset during the second data byte of a read
        a = 16'($urandom);
        cs_begin();
        spi_bits(8'h03, 8, r, o);
        spi_bits(a[15:8], 8, r, o);
        spi_bits(a[7:0], 8, r, o);
        spi_bits(8'h00, 8, r, o);
        spi_bits(8'h00, 3, r, o);
        rst_n = 1'b0;
        #1;
        check_eq("midrst miso",    {31'h0, spi_miso},    32'h0);
        check_eq("midrst miso_oe", {31'h0, spi_miso_oe}, 32'h0);
        check_eq("midrst active",  {31'h0, active},      32'h0);
        check_eq("midrst cmd_err", {31'h0, cmd_err},     32'h0);
        wait_clk(2);
        rst_n = 1'b1;
        ref_sr = 8'h40;
        r_any = 8'h00; o_any = 8'h00;
        for (int i = 0; i < 2; i++) begin
            spi_bits(8'h03, 8, r, o);
            r_any = r_any | r;
            o_any = o_any | o;
        end
        check_eq("postrst miso", {24'h0, r_any}, 32'h0);
        check_eq("postrst oe",   {24'h0, o_any}, 32'h0);
        cs_end();
        do_rdsr("postrst_rdsr", 2);
        do_read("postrst_mem", a, 4);

        check_eq("total cmd_err cycles", err_cycles, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
